// File: rtl/uart_agent_pkg.sv
// Shared definitions for the UART host agent.
//   tx_state_t / rx_state_t : state encodings of the transmit and receive FSMs
//   calc_div()              : clock cycles per oversample tick, rounded, at least 1
//   UART_IDLE_LVL           : level of an idle (marking) UART line
// Optional feature macro: UART_AGENT_PARITY_EN adds the parity states.
package uart_agent_pkg;

  localparam logic UART_IDLE_LVL = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
`ifdef UART_AGENT_PARITY_EN
    TX_PARITY = 3'd3,
`endif
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
`ifdef UART_AGENT_PARITY_EN
    RX_PARITY    = 3'd3,
`endif
    RX_STOP      = 3'd4,
    RX_WAIT_HIGH = 3'd5
  } rx_state_t;

  // round(clk_hz / (baud * oversample)), never below 1
  function automatic int unsigned calc_div(input longint unsigned clk_hz,
                                           input longint unsigned baud,
                                           input longint unsigned oversample);
    longint unsigned den;
    longint unsigned q;
    den = baud * oversample;
    if (den == 64'd0) return 32'd1;
    q = (clk_hz + den / 64'd2) / den;
    if (q < 64'd1) return 32'd1;
    return 32'(q);
  endfunction

endpackage

// File: rtl/uart_host_agent_sync_fifo.sv
// sync_fifo: single-clock FIFO with show-ahead read port.
//   clk, rst_n            : clock, asynchronous active-low reset (empties FIFO)
//   push, push_data, full : write side; push ignored when full unless popping
//   pop, pop_data, empty  : read side; pop_data is the head, 0 while empty;
//                           pop ignored when empty
// Full/empty come from an occupancy counter, so DEPTH must be a power of 2
// (pointers wrap naturally).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign do_push = push && (!full || pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_host_agent.sv
// uart_host_agent: UART host model with buffered byte streams.
//   clk, rst_n     : clock, asynchronous active-low reset
//   tx_data/valid/ready : byte stream into the TX FIFO
//   rx_data/valid/ready : byte stream out of the RX FIFO (show-ahead head)
//   uart_txd       : serial out (idle high)
//   uart_rxd       : serial in, asynchronous, synchronised internally
//   tx_busy        : frame on the line or bytes waiting in the TX FIFO
//   rx_frame_err   : 1-cycle pulse, stop bit sampled low
//   rx_overflow    : 1-cycle pulse, good byte dropped, RX FIFO full
//   rx_parity_err  : 1-cycle pulse, parity mismatch (0 unless parity built in)
// Optional feature macro: UART_AGENT_PARITY_EN (even parity after data bits).
//
// Handshake: a byte moves on the rising clk edge where valid and ready are
// both high; valid must not wait for ready, and data holds while valid is up.
//
// Internal FSM state is visible as tx_state / rx_state for checkers.
module uart_host_agent
  import uart_agent_pkg::*;
#(
  parameter int CLK_HZ     = 27_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 uart_txd,
  input  logic                 uart_rxd,
  output logic                 tx_busy,
  output logic                 rx_frame_err,
  output logic                 rx_overflow,
  output logic                 rx_parity_err
);

  localparam int unsigned DIV = calc_div(64'(CLK_HZ), 64'(BAUD), 64'(OVERSAMPLE));
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam int OW = $clog2(OVERSAMPLE);
  localparam logic [OW-1:0] OS_LAST = OW'(OVERSAMPLE - 1);
  localparam logic [OW-1:0] OS_MID  = OW'(OVERSAMPLE / 2 - 1);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic STOP_LAST = (STOP_BITS > 1);

  // ---------------------------------------------------------------- tick
  logic [DW-1:0] div_cnt;
  logic          tick;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // ---------------------------------------------------------------- FIFOs
  logic                 tx_full;
  logic                 tx_empty;
  logic                 tx_pop;
  logic [DATA_BITS-1:0] tx_head;
  logic                 rx_full;
  logic                 rx_empty;
  logic                 rx_push;
  logic [DATA_BITS-1:0] rx_sh;

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tx_valid),
    .push_data (tx_data),
    .full      (tx_full),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .empty     (tx_empty)
  );

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rx_push),
    .push_data (rx_sh),
    .full      (rx_full),
    .pop       (rx_ready),
    .pop_data  (rx_data),
    .empty     (rx_empty)
  );

  assign tx_ready = !tx_full;
  assign rx_valid = !rx_empty;

  // ---------------------------------------------------------------- TX
  tx_state_t            tx_state, tx_state_nxt;
  logic [OW-1:0]        tx_os, tx_os_nxt;
  logic [BW-1:0]        tx_bit, tx_bit_nxt;
  logic                 tx_stop, tx_stop_nxt;
  logic [DATA_BITS-1:0] tx_sh, tx_sh_nxt;
  logic                 txd_q, txd_nxt;
  logic                 tx_bit_end;
  logic                 tx_load;
`ifdef UART_AGENT_PARITY_EN
  logic                 tx_par, tx_par_nxt;
`endif

  assign tx_bit_end = tick && (tx_os == OS_LAST);
  assign uart_txd   = txd_q;
  assign tx_busy    = (tx_state != TX_IDLE) || !tx_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_os    <= '0;
      tx_bit   <= '0;
      tx_stop  <= 1'b0;
      tx_sh    <= '0;
      txd_q    <= UART_IDLE_LVL;
`ifdef UART_AGENT_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      tx_state <= tx_state_nxt;
      tx_os    <= tx_os_nxt;
      tx_bit   <= tx_bit_nxt;
      tx_stop  <= tx_stop_nxt;
      tx_sh    <= tx_sh_nxt;
      txd_q    <= txd_nxt;
`ifdef UART_AGENT_PARITY_EN
      tx_par   <= tx_par_nxt;
`endif
    end
  end

  always_comb begin
    tx_state_nxt = tx_state;
    tx_os_nxt    = tx_os;
    tx_bit_nxt   = tx_bit;
    tx_stop_nxt  = tx_stop;
    tx_sh_nxt    = tx_sh;
    tx_pop       = 1'b0;
    tx_load      = 1'b0;
    txd_nxt      = UART_IDLE_LVL;
`ifdef UART_AGENT_PARITY_EN
    tx_par_nxt   = tx_par;
`endif

    if (tick && (tx_state != TX_IDLE)) tx_os_nxt = tx_bit_end ? '0 : tx_os + 1'b1;

    case (tx_state)
      TX_IDLE: begin
        // start on a tick so the start bit is a full OVERSAMPLE ticks long
        if (tick && !tx_empty) tx_load = 1'b1;
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_state_nxt = TX_DATA;
          tx_bit_nxt   = '0;
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_sh_nxt = tx_sh >> 1;
          if (tx_bit == BIT_LAST) begin
`ifdef UART_AGENT_PARITY_EN
            tx_state_nxt = TX_PARITY;
`else
            tx_state_nxt = TX_STOP;
`endif
            tx_stop_nxt = 1'b0;
          end else begin
            tx_bit_nxt = tx_bit + 1'b1;
          end
        end
      end
`ifdef UART_AGENT_PARITY_EN
      TX_PARITY: begin
        if (tx_bit_end) begin
          tx_state_nxt = TX_STOP;
          tx_stop_nxt  = 1'b0;
        end
      end
`endif
      TX_STOP: begin
        if (tx_bit_end) begin
          if (tx_stop == STOP_LAST) begin
            // chain straight into the next start bit: no idle gap
            if (!tx_empty) tx_load = 1'b1;
            else           tx_state_nxt = TX_IDLE;
          end else begin
            tx_stop_nxt = 1'b1;
          end
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase

    if (tx_load) begin
      tx_pop       = 1'b1;
      tx_sh_nxt    = tx_head;
      tx_os_nxt    = '0;
      tx_state_nxt = TX_START;
`ifdef UART_AGENT_PARITY_EN
      tx_par_nxt   = ^tx_head;
`endif
    end

    // line level registered from the next state so uart_txd is glitch-free
    case (tx_state_nxt)
      TX_START:  txd_nxt = 1'b0;
      TX_DATA:   txd_nxt = tx_sh_nxt[0];
`ifdef UART_AGENT_PARITY_EN
      TX_PARITY: txd_nxt = tx_par_nxt;
`endif
      default:   txd_nxt = UART_IDLE_LVL;
    endcase
  end

  // ---------------------------------------------------------------- RX
  logic                 rxd_m, rxd_s, rxd_d;
  rx_state_t            rx_state, rx_state_nxt;
  logic [OW-1:0]        rx_os, rx_os_nxt;
  logic [BW-1:0]        rx_bit, rx_bit_nxt;
  logic [DATA_BITS-1:0] rx_sh_nxt;
  logic                 rx_push_req;
  logic                 fe_q, fe_nxt;
  logic                 ovf_q, ovf_nxt;
  logic                 perr_nxt;
`ifdef UART_AGENT_PARITY_EN
  logic                 rx_par, rx_par_nxt;
  logic                 perr_q;
`endif

  assign rx_frame_err = fe_q;
  assign rx_overflow  = ovf_q;
  // the FIFO takes the byte when not full or when the head leaves this cycle
  assign rx_push      = rx_push_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_m    <= UART_IDLE_LVL;
      rxd_s    <= UART_IDLE_LVL;
      rxd_d    <= UART_IDLE_LVL;
      rx_state <= RX_IDLE;
      rx_os    <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      fe_q     <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef UART_AGENT_PARITY_EN
      rx_par   <= 1'b0;
      perr_q   <= 1'b0;
`endif
    end else begin
      rxd_m    <= uart_rxd;
      rxd_s    <= rxd_m;
      rxd_d    <= rxd_s;
      rx_state <= rx_state_nxt;
      rx_os    <= rx_os_nxt;
      rx_bit   <= rx_bit_nxt;
      rx_sh    <= rx_sh_nxt;
      fe_q     <= fe_nxt;
      ovf_q    <= ovf_nxt;
`ifdef UART_AGENT_PARITY_EN
      rx_par   <= rx_par_nxt;
      perr_q   <= perr_nxt;
`endif
    end
  end

`ifdef UART_AGENT_PARITY_EN
  assign rx_parity_err = perr_q;
`else
  assign rx_parity_err = 1'b0;
`endif

  always_comb begin
    rx_state_nxt = rx_state;
    rx_os_nxt    = rx_os;
    rx_bit_nxt   = rx_bit;
    rx_sh_nxt    = rx_sh;
    rx_push_req  = 1'b0;
    fe_nxt       = 1'b0;
    ovf_nxt      = 1'b0;
    perr_nxt     = 1'b0;
`ifdef UART_AGENT_PARITY_EN
    rx_par_nxt   = rx_par;
`endif

    case (rx_state)
      RX_IDLE: begin
        if (rxd_d && !rxd_s) begin
          rx_state_nxt = RX_START;
          rx_os_nxt    = '0;
        end
      end
      RX_START: begin
        if (tick) begin
          if (rx_os == OS_MID) begin
            // a line back high at mid start bit was a glitch
            if (rxd_s) begin
              rx_state_nxt = RX_IDLE;
            end else begin
              rx_state_nxt = RX_DATA;
              rx_os_nxt    = '0;
              rx_bit_nxt   = '0;
            end
          end else begin
            rx_os_nxt = rx_os + 1'b1;
          end
        end
      end
      RX_DATA: begin
        // counting a full bit from mid start lands on each bit's middle
        if (tick) begin
          if (rx_os == OS_LAST) begin
            rx_os_nxt = '0;
            rx_sh_nxt = {rxd_s, rx_sh[DATA_BITS-1:1]};
            if (rx_bit == BIT_LAST) begin
`ifdef UART_AGENT_PARITY_EN
              rx_state_nxt = RX_PARITY;
`else
              rx_state_nxt = RX_STOP;
`endif
            end else begin
              rx_bit_nxt = rx_bit + 1'b1;
            end
          end else begin
            rx_os_nxt = rx_os + 1'b1;
          end
        end
      end
`ifdef UART_AGENT_PARITY_EN
      RX_PARITY: begin
        if (tick) begin
          if (rx_os == OS_LAST) begin
            rx_os_nxt    = '0;
            rx_par_nxt   = rxd_s;
            rx_state_nxt = RX_STOP;
          end else begin
            rx_os_nxt = rx_os + 1'b1;
          end
        end
      end
`endif
      RX_STOP: begin
        // only the first stop bit is checked; extra stop bits are idle line
        if (tick) begin
          if (rx_os == OS_LAST) begin
            rx_os_nxt = '0;
            if (rxd_s) begin
              rx_state_nxt = RX_IDLE;
              rx_push_req  = 1'b1;
              ovf_nxt      = rx_full && !rx_ready;
`ifdef UART_AGENT_PARITY_EN
              perr_nxt     = (^rx_sh) ^ rx_par;
`endif
            end else begin
              fe_nxt       = 1'b1;
              rx_state_nxt = RX_WAIT_HIGH;
            end
          end else begin
            rx_os_nxt = rx_os + 1'b1;
          end
        end
      end
      RX_WAIT_HIGH: begin
        if (rxd_s) rx_state_nxt = RX_IDLE;
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  // perr_nxt is only consumed when parity is built in
  logic unused_perr;
  assign unused_perr = perr_nxt;

endmodule

// File: tb/tb_uart_host_agent.sv
// Bench for uart_host_agent with default parameters (DIV=15, 240 cycles/bit).
// Directed sequence with randomized bytes and gaps; a byte-level model
// (frame bit list, depth-limited expected queue, error counters) supplies
// every expected value.
module tb_uart_host_agent;

  localparam int CLK_HZ   = 27_000_000;
  localparam int BAUD     = 115200;
  localparam int OS       = 16;
  localparam int DB       = 8;
  localparam int SB       = 1;
  localparam int DEPTH    = 16;
  localparam int DIV_M    = (CLK_HZ + (BAUD * OS) / 2) / (BAUD * OS);
  localparam int BIT_CYC  = DIV_M * OS;
`ifdef UART_AGENT_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FRAME_BITS = 1 + DB + PAR_BITS + SB;

  // ---------------------------------------------------- clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DB-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready = 1'b0;
  logic          uart_txd;
  logic          uart_rxd;
  logic          tx_busy;
  logic          rx_frame_err;
  logic          rx_overflow;
  logic          rx_parity_err;
  logic          loopback = 1'b0;
  logic          rxd_drv = 1'b1;

  assign uart_rxd = loopback ? uart_txd : rxd_drv;

  uart_host_agent #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS),
    .DATA_BITS(DB), .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .uart_txd(uart_txd), .uart_rxd(uart_rxd), .tx_busy(tx_busy),
    .rx_frame_err(rx_frame_err), .rx_overflow(rx_overflow),
    .rx_parity_err(rx_parity_err)
  );

  int unsigned cyc = 0;
  int fe_cnt = 0, ovf_cnt = 0, perr_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rx_frame_err)  fe_cnt   <= fe_cnt + 1;
    if (rx_overflow)   ovf_cnt  <= ovf_cnt + 1;
    if (rx_parity_err) perr_cnt <= perr_cnt + 1;
  end

  initial begin
    #2_500_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------- scoreboard / model
  int checks = 0;
  int errors = 0;
  logic [DB-1:0] exp_q[$];
  int exp_fe = 0, exp_ovf = 0, exp_perr = 0;
  logic fbits[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // line levels of one frame, start bit first, data LSB first
  function automatic void build_frame(input logic [DB-1:0] d, input logic stop_lvl,
                                      input logic par_bad);
    int ones;
    ones = 0;
    fbits.delete();
    fbits.push_back(1'b0);
    for (int i = 0; i < DB; i++) begin
      fbits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (PAR_BITS != 0) fbits.push_back(((ones % 2) == 1) ^ par_bad);
    for (int i = 0; i < SB; i++) fbits.push_back(stop_lvl);
  endfunction

  // what the receiver should do with one frame while nothing is read out
  task automatic model_rx(input logic [DB-1:0] d, input logic stop_lvl, input logic par_bad);
    if (!stop_lvl) begin
      exp_fe++;
    end else begin
      if ((PAR_BITS != 0) && par_bad) exp_perr++;
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else exp_ovf++;
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_frame_err"}, 32'(fe_cnt), 32'(exp_fe));
    check({tag, "_overflow"}, 32'(ovf_cnt), 32'(exp_ovf));
    check({tag, "_parity_err"}, 32'(perr_cnt), 32'(exp_perr));
  endtask

  // ---------------------------------------------------- driver tasks
  task automatic push_tx(input logic [DB-1:0] d);
    int n;
    n = 0;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) check("tx_push_timeout", 32'(tx_ready), 32'd1);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic drive_frame(input logic [DB-1:0] d, input logic stop_lvl, input logic par_bad);
    build_frame(d, stop_lvl, par_bad);
    @(negedge clk);
    foreach (fbits[i]) begin
      rxd_drv = fbits[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    rxd_drv = 1'b1;
  endtask

  task automatic pop_rx(output logic [DB-1:0] d, output logic ok);
    int n;
    n = 0;
    ok = 1'b0;
    d = '0;
    @(negedge clk);
    while (!rx_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (rx_valid) begin
      d = rx_data;
      ok = 1'b1;
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
  endtask

  task automatic drain_check(input string tag);
    logic [DB-1:0] got;
    logic [DB-1:0] exp;
    logic ok;
    while (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      pop_rx(got, ok);
      check({tag, "_rx_avail"}, 32'(ok), 32'd1);
      if (ok) check({tag, "_rx_byte"}, 32'(got), 32'(exp));
    end
    @(negedge clk);
    check({tag, "_rx_empty"}, 32'(rx_valid), 32'd0);
  endtask

  task automatic wait_tx_idle(input string tag);
    int n;
    n = 0;
    while (tx_busy && n < 40000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_tx_idle"}, 32'(tx_busy), 32'd0);
  endtask

  // waits for the start bit after a handshake; returns cycles waited
  task automatic wait_txd_low(output int n);
    n = 0;
    while (uart_txd !== 1'b0 && n < 4 * DIV_M) begin
      @(negedge clk);
      n++;
    end
  endtask

  // ---------------------------------------------------- sequence
  logic [DB-1:0] b;
  logic [DB-1:0] fixed_bytes[5];
  int n;
  int unsigned t0;

  initial begin
    fixed_bytes[0] = 8'h00; fixed_bytes[1] = 8'hFF; fixed_bytes[2] = 8'hA5;
    fixed_bytes[3] = 8'h3C; fixed_bytes[4] = 8'h81;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(uart_txd), 32'd1);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_pulses", {29'd0, rx_frame_err, rx_overflow, rx_parity_err}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // TX waveform of 0x55, start latency and whole-frame length
    push_tx(8'h55);
    wait_txd_low(n);
    check("tx_start_latency_ok", 32'(n <= DIV_M + 2), 32'd1);
    t0 = cyc;
    build_frame(8'h55, 1'b1, 1'b0);
    repeat (BIT_CYC / 2) @(negedge clk);
    for (int k = 0; k < FRAME_BITS; k++) begin
      check($sformatf("tx_bit%0d", k), 32'(uart_txd), 32'(fbits[k]));
      check($sformatf("tx_busy%0d", k), 32'(tx_busy), 32'd1);
      if (k != FRAME_BITS - 1) repeat (BIT_CYC) @(negedge clk);
    end
    wait_tx_idle("t1");
    check("frame_len", cyc - t0, 32'(FRAME_BITS * BIT_CYC));
    check("t1_txd_idle", 32'(uart_txd), 32'd1);

    // loopback, fixed bytes
    loopback = 1'b1;
    foreach (fixed_bytes[i]) begin
      push_tx(fixed_bytes[i]);
      model_rx(fixed_bytes[i], 1'b1, 1'b0);
    end
    wait_tx_idle("t2");
    repeat (20) @(negedge clk);
    drain_check("t2");
    check_flags("t2");

    // loopback, random bytes
    for (int i = 0; i < 3; i++) begin
      b = DB'($urandom_range(0, 255));
      push_tx(b);
      model_rx(b, 1'b1, 1'b0);
    end
    wait_tx_idle("t2r");
    repeat (20) @(negedge clk);
    drain_check("t2r");
    loopback = 1'b0;

    // short low glitches: no frame, no flag
    @(negedge clk);
    rxd_drv = 1'b0;
    repeat (50) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (400) @(negedge clk);
    rxd_drv = 1'b0;
    repeat ($urandom_range(20, 60)) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (600) @(negedge clk);
    check("glitch_rx_valid", 32'(rx_valid), 32'd0);
    check_flags("glitch");

    // stop bit low, then a good frame
    drive_frame(8'h41, 1'b0, 1'b0);
    model_rx(8'h41, 1'b0, 1'b0);
    check("ferr_rx_valid", 32'(rx_valid), 32'd0);
    check_flags("ferr");
    repeat (2 * BIT_CYC) @(negedge clk);
    drive_frame(8'h42, 1'b1, 1'b0);
    model_rx(8'h42, 1'b1, 1'b0);
    drain_check("after_ferr");
    check_flags("after_ferr");

`ifdef UART_AGENT_PARITY_EN
    // bad parity bit: flagged, byte still delivered
    drive_frame(8'h07, 1'b1, 1'b1);
    model_rx(8'h07, 1'b1, 1'b1);
    drain_check("parity");
    check_flags("parity");
`endif

    // overflow: 17 frames with the consumer stalled
    rx_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      b = DB'(i);
      drive_frame(b, 1'b1, 1'b0);
      model_rx(b, 1'b1, 1'b0);
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end
    check_flags("ovf");
    drain_check("ovf");

    // reset in the middle of data bit 3
    b = DB'($urandom_range(0, 255));
    push_tx(b);
    wait_txd_low(n);
    check("t7_start_seen", 32'(uart_txd), 32'd0);
    repeat (4 * BIT_CYC + BIT_CYC / 2) @(negedge clk);
    check("t7_bit3", 32'(uart_txd), 32'(b[3]));
    rst_n = 1'b0;
    #1;
    check("t7_txd_in_reset", 32'(uart_txd), 32'd1);
    check("t7_tx_ready_in_reset", 32'(tx_ready), 32'd1);
    check("t7_tx_busy_in_reset", 32'(tx_busy), 32'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t7_rx_valid", 32'(rx_valid), 32'd0);
    check("t7_tx_ready", 32'(tx_ready), 32'd1);
    repeat (300) @(negedge clk);
    check("t7_txd_stays_idle", 32'(uart_txd), 32'd1);
    check("t7_tx_busy_stays_low", 32'(tx_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
